// File: rtl/node_pkg.sv
// Shared Q16.16 fixed-point types, constants and saturation
// for the node chain.
package node_pkg;

    typedef logic signed [31:0] fx_t;
    typedef logic signed [35:0] fx_wide_t;

    localparam fx_t FX_ONE = 32'sh0001_0000;
    localparam fx_t FX_MAX = 32'sh7FFF_FFFF;
    localparam fx_t FX_MIN = 32'sh8000_0000;

    // Clamp a wide signed sum back into the Q16.16 range.
    function automatic fx_t fx_sat(input fx_wide_t v);
        if (v > fx_wide_t'(FX_MAX))
            return FX_MAX;
        else if (v < fx_wide_t'(FX_MIN))
            return FX_MIN;
        else
            return fx_t'(v[31:0]);
    endfunction

endpackage

// File: rtl/node_fx_sat.sv
// Verlet position step for one axis: sat(2*cur - prev + accel).
// Ports: cur, prev, accel (Q16.16 in), result (Q16.16 out).
module node_fx_sat
    import node_pkg::*;
(
    input  fx_t cur,
    input  fx_t prev,
    input  fx_t accel,
    output fx_t result
);

    fx_wide_t sum;

    // 36 bits hold the worst case |2*cur| + |prev| + |accel| = 2^33.
    always_comb begin
        sum    = (fx_wide_t'(cur) <<< 1)
               - fx_wide_t'(prev)
               + fx_wide_t'(accel);
        result = fx_sat(sum);
    end

endmodule

// File: rtl/node.sv
// One mass point of a Verlet rope: integrates under gravity and
// accepts constraint-corrected positions from an external solver.
// Ports: clk, reset (async, active-high), integrate_en,
//   constrain_en, x_enforced/y_enforced (Q16.16 in),
//   x_pos/y_pos (Q16.16 out, registered), finish.
module node
    import node_pkg::*;
#(
    parameter int  INDEX     = 0,
    parameter fx_t SPACING   = FX_ONE,
    parameter fx_t GRAVITY   = 32'shFFFF_FF00,
    parameter bit  PINNED    = 1'b0,
    parameter int  MAX_STEPS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        integrate_en,
    input  logic        constrain_en,
    input  logic [31:0] x_enforced,
    input  logic [31:0] y_enforced,
    output logic [31:0] x_pos,
    output logic [31:0] y_pos,
    output logic        finish
);

    localparam int CW = $clog2(MAX_STEPS + 1);
    localparam logic [63:0] X_PROD = 64'(INDEX) * 64'(SPACING);
    localparam fx_t X_RST = fx_t'(X_PROD[31:0]);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STEPS);

    fx_t x_prev;
    fx_t y_prev;
    fx_t x_next;
    fx_t y_next;
    logic [CW-1:0] step_cnt;
    logic [CW-1:0] cnt_inc;
    logic do_int;

    // Constrain wins over integrate; a finished node stops integrating.
    assign do_int  = integrate_en & ~constrain_en & ~finish;
    assign cnt_inc = step_cnt + 1'b1;

    node_fx_sat u_sat_x (
        .cur    (fx_t'(x_pos)),
        .prev   (x_prev),
        .accel  ('0),
        .result (x_next)
    );

    node_fx_sat u_sat_y (
        .cur    (fx_t'(y_pos)),
        .prev   (y_prev),
        .accel  (GRAVITY),
        .result (y_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_pos    <= X_RST;
            x_prev   <= X_RST;
            y_pos    <= '0;
            y_prev   <= '0;
            step_cnt <= '0;
            finish   <= 1'b0;
        end else begin
            // A pinned node keeps its reset position but still counts.
            if (!PINNED) begin
                if (constrain_en) begin
                    x_pos <= x_enforced;
                    y_pos <= y_enforced;
                end else if (do_int) begin
                    x_pos  <= x_next;
                    y_pos  <= y_next;
                    x_prev <= x_pos;
                    y_prev <= y_pos;
                end
            end
            // Gating on finish keeps the counter saturated at MAX_STEPS.
            if (do_int) begin
                step_cnt <= cnt_inc;
                finish   <= (cnt_inc == CNT_MAX);
            end
        end
    end

endmodule

// File: tb/tb_node.sv
// Self-checking bench for node: three parameterisations driven
// in parallel against a behavioural Verlet model.
module tb_node;

    logic        clk = 1'b0;
    logic        reset;
    logic        ie;
    logic        ce;
    logic [31:0] xe;
    logic [31:0] ye;
    logic [31:0] xo [3];
    logic [31:0] yo [3];
    logic        fo [3];

    int total = 0;
    int bad   = 0;

    localparam int M_IDX [3] = '{3, 0, 2};
    localparam int M_PIN [3] = '{0, 0, 1};
    localparam int M_MAX [3] = '{4, 1024, 4};

    int mx [3];
    int my [3];
    int px [3];
    int py [3];
    int mc [3];
    bit mf [3];

    node #(.INDEX(3), .MAX_STEPS(4)) u_a (
        .clk(clk), .reset(reset),
        .integrate_en(ie), .constrain_en(ce),
        .x_enforced(xe), .y_enforced(ye),
        .x_pos(xo[0]), .y_pos(yo[0]), .finish(fo[0])
    );

    node #(.INDEX(0)) u_b (
        .clk(clk), .reset(reset),
        .integrate_en(ie), .constrain_en(ce),
        .x_enforced(xe), .y_enforced(ye),
        .x_pos(xo[1]), .y_pos(yo[1]), .finish(fo[1])
    );

    node #(.INDEX(2), .PINNED(1'b1), .MAX_STEPS(4)) u_p (
        .clk(clk), .reset(reset),
        .integrate_en(ie), .constrain_en(ce),
        .x_enforced(xe), .y_enforced(ye),
        .x_pos(xo[2]), .y_pos(yo[2]), .finish(fo[2])
    );

    always #5 clk = ~clk;

    function automatic int sat(input longint v);
        if (v > 64'sd2147483647)
            return int'(32'h7FFF_FFFF);
        if (v < -64'sd2147483648)
            return int'(32'h8000_0000);
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mx[k] = M_IDX[k] * 65536;
            px[k] = mx[k];
            my[k] = 0;
            py[k] = 0;
            mc[k] = 0;
            mf[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit i, input bit c,
                              input int x, input int y);
        int nx;
        int ny;
        for (int k = 0; k < 3; k++) begin
            if (c) begin
                if (M_PIN[k] == 0) begin
                    mx[k] = x;
                    my[k] = y;
                end
            end else if (i && !mf[k]) begin
                if (M_PIN[k] == 0) begin
                    nx = sat(2 * longint'(mx[k]) - longint'(px[k]));
                    ny = sat(2 * longint'(my[k]) - longint'(py[k])
                             - 64'sd256);
                    px[k] = mx[k];
                    py[k] = my[k];
                    mx[k] = nx;
                    my[k] = ny;
                end
                mc[k]++;
                mf[k] = (mc[k] == M_MAX[k]);
            end
        end
    endtask

    task automatic cycle(input bit i, input bit c,
                         input logic [31:0] x, input logic [31:0] y);
        ie = i;
        ce = c;
        xe = x;
        ye = y;
        @(posedge clk);
        model_step(i, c, int'(x), int'(y));
        #1;
        ie = 1'b0;
        ce = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ie = 1'b0;
        ce = 1'b0;
        xe = '0;
        ye = '0;
        #2;
        model_reset();
        total++;
        if (xo[0] !== 32'h0003_0000 || yo[0] !== 32'h0
            || fo[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_idx3 got x=%h y=%h f=%b want 00030000/0/0",
                     xo[0], yo[0], fo[0]);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (xo[k] !== 32'(mx[k]) || yo[k] !== 32'(my[k])
                || fo[k] !== mf[k]) begin
                bad++;
                $display("FAIL reset_model n%0d got %h/%h/%b want %h/%h/%b",
                         k, xo[k], yo[k], fo[k], mx[k], my[k], mf[k]);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_free_fall();
        logic [31:0] e [3];
        e[0] = 32'hFFFF_FF00;
        e[1] = 32'hFFFF_FD00;
        e[2] = 32'hFFFF_FA00;
        pulse_reset();
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 1'b0, '0, '0);
            total++;
            if (yo[1] !== e[n] || xo[1] !== 32'h0) begin
                bad++;
                $display("FAIL free_fall step%0d got x=%h y=%h want 0/%h",
                         n, xo[1], yo[1], e[n]);
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (xo[k] !== 32'(mx[k]) || yo[k] !== 32'(my[k])
                    || fo[k] !== mf[k]) begin
                    bad++;
                    $display("FAIL free_fall_model n%0d got %h/%h/%b want %h/%h/%b",
                             k, xo[k], yo[k], fo[k], mx[k], my[k], mf[k]);
                end
            end
        end
    endtask

    task automatic test_constrain();
        pulse_reset();
        cycle(1'b0, 1'b1, 32'h0002_8000, 32'hFFFF_0000);
        total++;
        if (xo[1] !== 32'h0002_8000 || yo[1] !== 32'hFFFF_0000) begin
            bad++;
            $display("FAIL constrain_load got %h/%h want 00028000/ffff0000",
                     xo[1], yo[1]);
        end
        total++;
        if (xo[2] !== 32'h0002_0000 || yo[2] !== 32'h0) begin
            bad++;
            $display("FAIL constrain_pinned got %h/%h want 00020000/0",
                     xo[2], yo[2]);
        end
        cycle(1'b1, 1'b0, '0, '0);
        total++;
        if (xo[1] !== 32'h0005_0000 || yo[1] !== 32'hFFFD_FF00) begin
            bad++;
            $display("FAIL constrain_integrate got %h/%h want 00050000/fffdff00",
                     xo[1], yo[1]);
        end
    endtask

    task automatic test_both_strobes();
        pulse_reset();
        cycle(1'b1, 1'b1, 32'h0000_1234, 32'h0);
        total++;
        if (xo[1] !== 32'h0000_1234 || yo[1] !== 32'h0) begin
            bad++;
            $display("FAIL both_strobes got %h/%h want 00001234/0",
                     xo[1], yo[1]);
        end
        cycle(1'b1, 1'b1, 32'h1234_0000, 32'h0);
        total++;
        if (xo[2] !== 32'h0002_0000) begin
            bad++;
            $display("FAIL both_pinned got x=%h want 00020000", xo[2]);
        end
        // Counter must not have moved: finish rises on the 4th integrate.
        for (int n = 0; n < 4; n++) begin
            cycle(1'b1, 1'b0, '0, '0);
            total++;
            if (fo[0] !== (n == 3) || fo[2] !== (n == 3)) begin
                bad++;
                $display("FAIL both_count step%0d got f=%b/%b want %b",
                         n, fo[0], fo[2], (n == 3));
            end
        end
    endtask

    task automatic test_saturate();
        pulse_reset();
        cycle(1'b0, 1'b1, 32'h0, 32'h8000_0100);
        cycle(1'b1, 1'b0, '0, '0);
        total++;
        if (yo[1] !== 32'h8000_0000) begin
            bad++;
            $display("FAIL sat_neg got y=%h want 80000000", yo[1]);
        end
        cycle(1'b0, 1'b1, 32'h7FFF_0000, 32'h0);
        cycle(1'b1, 1'b0, '0, '0);
        total++;
        if (xo[1] !== 32'h7FFF_FFFF) begin
            bad++;
            $display("FAIL sat_pos got x=%h want 7fffffff", xo[1]);
        end
    endtask

    task automatic test_max_steps();
        logic [31:0] y_hold;
        pulse_reset();
        for (int n = 0; n < 4; n++)
            cycle(1'b1, 1'b0, '0, '0);
        total++;
        if (fo[0] !== 1'b1 || fo[1] !== 1'b0) begin
            bad++;
            $display("FAIL finish_rise got %b/%b want 1/0", fo[0], fo[1]);
        end
        y_hold = yo[0];
        cycle(1'b1, 1'b0, '0, '0);
        total++;
        if (yo[0] !== y_hold || fo[0] !== 1'b1
            || yo[0] !== 32'(my[0])) begin
            bad++;
            $display("FAIL finish_hold got y=%h f=%b want %h/1",
                     yo[0], fo[0], y_hold);
        end
        cycle(1'b0, 1'b1, 32'h1111_0000, 32'h2222_0000);
        total++;
        if (xo[0] !== 32'h1111_0000 || yo[0] !== 32'h2222_0000) begin
            bad++;
            $display("FAIL finish_constrain got %h/%h want 11110000/22220000",
                     xo[0], yo[0]);
        end
        ie = 1'b1;
        reset = 1'b1;
        #1;
        model_reset();
        total++;
        if (xo[0] !== 32'h0003_0000 || yo[0] !== 32'h0
            || fo[0] !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got %h/%h/%b want 00030000/0/0",
                     xo[0], yo[0], fo[0]);
        end
        @(posedge clk);
        #1;
        total++;
        if (xo[0] !== 32'h0003_0000 || yo[0] !== 32'h0) begin
            bad++;
            $display("FAIL reset_over_strobe got %h/%h want 00030000/0",
                     xo[0], yo[0]);
        end
        reset = 1'b0;
        ie = 1'b0;
        cycle(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (xo[k] !== 32'(mx[k]) || yo[k] !== 32'(my[k])
                || fo[k] !== mf[k]) begin
                bad++;
                $display("FAIL resume_model n%0d got %h/%h/%b want %h/%h/%b",
                         k, xo[k], yo[k], fo[k], mx[k], my[k], mf[k]);
            end
        end
    endtask

    task automatic test_random();
        bit          i;
        bit          c;
        logic [31:0] x;
        logic [31:0] y;
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 0)
                pulse_reset();
            i = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                x = $urandom;
                y = $urandom;
            end else begin
                x = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
                y = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
            end
            cycle(i, c, x, y);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (xo[k] !== 32'(mx[k]) || yo[k] !== 32'(my[k])
                    || fo[k] !== mf[k]) begin
                    bad++;
                    $display("FAIL random c%0d n%0d got %h/%h/%b want %h/%h/%b",
                             n, k, xo[k], yo[k], fo[k], mx[k], my[k], mf[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_fall();
        test_constrain();
        test_both_strobes();
        test_saturate();
        test_max_steps();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
